// File: rtl/edge_event_arb_pkg.sv
// Shared encodings for the edge event arbiter: channel modes, FSM states, default widths.
// Timestamp support is enabled by defining EDGE_EVENT_ARB_TIMESTAMP_EN.
package edge_event_arb_pkg;

   localparam logic [1:0] MODE_OFF  = 2'b00;
   localparam logic [1:0] MODE_RISE = 2'b01;
   localparam logic [1:0] MODE_FALL = 2'b10;
   localparam logic [1:0] MODE_BOTH = 2'b11;

   localparam int unsigned TS_W_DEFAULT = 16;

   typedef enum logic [0:0] {
      StIdle,
      StPresent
   } arb_state_e;

endpackage

// File: rtl/edge_capture_ch.sv
// One channel: edge detection, mode qualification, single-entry pending event and sticky overflow.
// With EDGE_EVENT_ARB_TIMESTAMP_EN defined, the pending event also carries a capture timestamp.
module edge_capture_ch
   import edge_event_arb_pkg::*;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
#(
   parameter int unsigned TS_W = TS_W_DEFAULT
)
`endif
(
   input  logic            clk,
   input  logic            rst,
   input  logic            sig_in,
   input  logic [1:0]      mode,
   input  logic            grant,
   input  logic            ovf_clr,
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
   input  logic [TS_W-1:0] ts,
   output logic [TS_W-1:0] pend_ts,
`endif
   output logic            pend,
   output logic            pend_rise,
   output logic            ovf
);

   logic sig_d_q;
   logic pend_q, pend_d;
   logic rise_q, rise_d;
   logic ovf_q, ovf_d;
   logic rise_edge, fall_edge, hit, ovf_set;
   logic want_rise, want_fall;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
   logic [TS_W-1:0] ts_q, ts_d;
`endif

   always_comb begin
      rise_edge = sig_in & ~sig_d_q;
      fall_edge = ~sig_in & sig_d_q;
      want_rise = (mode == MODE_RISE) || (mode == MODE_BOTH);
      want_fall = (mode == MODE_FALL) || (mode == MODE_BOTH);
      hit       = (rise_edge & want_rise) | (fall_edge & want_fall);

      // A grant this cycle frees the slot, so a coincident edge reloads instead of overflowing.
      pend_d  = pend_q & ~grant;
      rise_d  = rise_q;
      ovf_set = 1'b0;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
      ts_d    = ts_q;
`endif
      if (mode == MODE_OFF) begin
         pend_d = 1'b0;
      end else if (hit) begin
         if (pend_d) begin
            ovf_set = 1'b1;
         end else begin
            pend_d = 1'b1;
            rise_d = rise_edge;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
            ts_d   = ts;
`endif
         end
      end
      ovf_d = ovf_set | (ovf_q & ~ovf_clr);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_d_q <= 1'b0;
         pend_q  <= 1'b0;
         rise_q  <= 1'b0;
         ovf_q   <= 1'b0;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
         ts_q    <= '0;
`endif
      end else begin
         sig_d_q <= sig_in;
         pend_q  <= pend_d;
         rise_q  <= rise_d;
         ovf_q   <= ovf_d;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
         ts_q    <= ts_d;
`endif
      end
   end

   assign pend      = pend_q;
   assign pend_rise = rise_q;
   assign ovf       = ovf_q;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
   assign pend_ts   = ts_q;
`endif

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel edge event controller sharing one valid/ready event port via round-robin.
// Defining EDGE_EVENT_ARB_TIMESTAMP_EN adds a free-running counter and the evt_ts output.
module edge_event_arbiter
   import edge_event_arb_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CH_W   = $clog2(NUM_CH),
   parameter int unsigned TS_W   = TS_W_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_CH-1:0]   sig_in,
   input  logic [2*NUM_CH-1:0] cfg_mode,
   output logic                evt_valid,
   input  logic                evt_ready,
   output logic [CH_W-1:0]     evt_ch,
   output logic                evt_rise,
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
   output logic [TS_W-1:0]     evt_ts,
`endif
   output logic [NUM_CH-1:0]   ovf,
   input  logic [NUM_CH-1:0]   ovf_clr
);

   if (NUM_CH < 2 || NUM_CH > 16 || CH_W < $clog2(NUM_CH) || TS_W < 1) begin : g_bad_cfg
      $error("edge_event_arbiter: unsupported NUM_CH/CH_W/TS_W");
   end

   arb_state_e        state_q, state_d;
   logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
   logic              evt_rise_q, evt_rise_d;
   logic [NUM_CH-1:0] pend, pend_rise, grant;
   logic [NUM_CH-1:0] pend_rot;
   logic [CH_W-1:0]   search_start, ch_inc, offs, sel_ch;
   logic [CH_W:0]     sel_sum;
   logic              sel_found, do_grant;
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
   logic [TS_W-1:0]   ts_q;
   logic [TS_W-1:0]   evt_ts_q, evt_ts_d;
   logic [TS_W-1:0]   pend_ts [NUM_CH];
`endif

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      edge_capture_ch
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
      #(
         .TS_W (TS_W)
      )
`endif
      u_ch (
         .clk       (clk),
         .rst       (rst),
         .sig_in    (sig_in[i]),
         .mode      (cfg_mode[2*i +: 2]),
         .grant     (grant[i]),
         .ovf_clr   (ovf_clr[i]),
`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
         .ts        (ts_q),
         .pend_ts   (pend_ts[i]),
`endif
         .pend      (pend[i]),
         .pend_rise (pend_rise[i]),
         .ovf       (ovf[i])
      );
   end

   assign ch_inc = (evt_ch_q == CH_W'(NUM_CH - 1)) ? '0 : evt_ch_q + 1'b1;

   // Rotate pendings so bit 0 is the search start, then take the lowest set bit.
   always_comb begin
      search_start = (state_q == StIdle) ? rr_ptr_q : ch_inc;
      pend_rot     = (pend >> search_start) | (pend << (NUM_CH - 32'(search_start)));
      sel_found    = 1'b0;
      offs         = '0;
      for (int j = 0; j < NUM_CH; j++) begin
         if (!sel_found && pend_rot[j]) begin
            sel_found = 1'b1;
            offs      = CH_W'(j);
         end
      end
      sel_sum = {1'b0, search_start} + {1'b0, offs};
      if (sel_sum >= (CH_W + 1)'(NUM_CH)) begin
         sel_sum = sel_sum - (CH_W + 1)'(NUM_CH);
      end
      sel_ch = sel_sum[CH_W-1:0];
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      evt_ch_d   = evt_ch_q;
      evt_rise_d = evt_rise_q;
      do_grant   = 1'b0;
      case (state_q)
         StIdle: begin
            if (sel_found) begin
               do_grant = 1'b1;
               state_d  = StPresent;
            end
         end
         StPresent: begin
            if (evt_ready) begin
               rr_ptr_d = ch_inc;
               if (sel_found) begin
                  do_grant = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
      if (do_grant) begin
         evt_ch_d   = sel_ch;
         evt_rise_d = pend_rise[sel_ch];
      end
      grant = do_grant ? (NUM_CH'(1) << sel_ch) : '0;
   end

`ifdef EDGE_EVENT_ARB_TIMESTAMP_EN
   always_comb begin
      evt_ts_d = evt_ts_q;
      if (do_grant) begin
         evt_ts_d = pend_ts[sel_ch];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q     <= '0;
         evt_ts_q <= '0;
      end else begin
         ts_q     <= ts_q + 1'b1;
         evt_ts_q <= evt_ts_d;
      end
   end

   assign evt_ts = evt_ts_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         rr_ptr_q   <= '0;
         evt_ch_q   <= '0;
         evt_rise_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         evt_ch_q   <= evt_ch_d;
         evt_rise_q <= evt_rise_d;
      end
   end

   assign evt_valid = (state_q == StPresent);
   assign evt_ch    = evt_ch_q;
   assign evt_rise  = evt_rise_q;

endmodule
